// File: rtl/imem_loader_if.sv
// Loader-side bundle: the byte-stream handshake from the off-chip loader,
// the instruction-memory write port, and the load status/CPU hold lines.
interface imem_loader_if #(
    parameter int ADDR_W = 32
) ();
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              busy;
    logic              done;
    logic              error;
    logic              cpu_hold;

    // Master drives the stream and observes the loader; slave is the loader itself.
    modport master (
        output start, in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_hold
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_hold
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory programmer: takes LEN_LO, LEN_HI, LEN payload bytes and
// an XOR checksum over a valid/ready stream, writes payload bytes to byte
// addresses 0..LEN-1 and releases the CPU only after a clean load.
module imem_loader #(
    parameter int MEM_BYTES = 36,
    parameter int ADDR_W    = 32
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(MEM_BYTES);

    state_t            state;
    logic [15:0]       len;
    logic [15:0]       cnt;
    logic [7:0]        csum;
    logic              in_ready_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic              cpu_hold_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              accept;

    assign accept = bus.in_valid & in_ready_q;

    // Whole loader FSM; status flags are updated together with each transition
    // so every output comes straight from a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            len         <= '0;
            cnt         <= '0;
            csum        <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_hold_q  <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (bus.start) begin
                        state      <= LEN_LO;
                        cnt        <= '0;
                        csum       <= '0;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        cpu_hold_q <= 1'b1;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len[7:0] <= bus.in_data;
                        state    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        len[15:8] <= bus.in_data;
                        if ({1'b0, bus.in_data, len[7:0]} > MAX_LEN) begin
                            state      <= ERROR;
                            error_q    <= 1'b1;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                        end else if ({bus.in_data, len[7:0]} == 16'd0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= ADDR_W'(cnt);
                        mem_wdata_q <= bus.in_data;
                        csum        <= csum ^ bus.in_data;
                        cnt         <= cnt + 16'd1;
                        if (cnt == len - 16'd1) begin
                            state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        if (bus.in_data == csum) begin
                            state      <= DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state   <= ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    cpu_hold_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.cpu_hold  = cpu_hold_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream programmer for the byte-wide instruction memory. It accepts a length-prefixed, checksummed byte stream over a valid/ready handshake and writes each payload byte into sequential instruction-memory byte addresses, starting at 0. The CPU is held in reset until a load completes with a correct checksum. It sits between the off-chip/bench loader interface and the instruction memory's write port; the instruction-fetch side stays read-only.

## Interface
Parameters:
- MEM_BYTES, 36, instruction memory size in bytes; maximum accepted payload length
- ADDR_W, 32, width of mem_addr

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader can accept a byte this cycle
- mem_we  out  1  byte write strobe to instruction memory
- mem_addr  out  ADDR_W  byte address of the write
- mem_wdata  out  8  byte to write
- busy  out  1  load in progress (states LEN_LO through CSUM)
- done  out  1  last load completed with a good checksum; level
- error  out  1  last load failed; level
- cpu_hold  out  1  holds the CPU in reset; low only in DONE

## Operation
- Transfer: a byte is accepted on a rising clk edge where in_valid & in_ready are both 1. Back-to-back acceptance on every cycle is allowed. in_data is ignored when no transfer takes place.
- Stream format: LEN[7:0], LEN[15:8], LEN payload bytes, CSUM. CSUM must equal the XOR of all payload bytes.
- States and transitions:
  - IDLE: entered on reset. start -> LEN_LO.
  - LEN_LO: accept the low length byte -> LEN_HI.
  - LEN_HI: accept the high length byte. If LEN > MEM_BYTES -> ERROR. If LEN == 0 -> CSUM. Otherwise -> DATA.
  - DATA: on each accepted byte, write it to address cnt, fold it into the running XOR, and increment cnt. The byte with cnt == LEN-1 moves the block to CSUM.
  - CSUM: accept one byte. If it equals the running XOR -> DONE, otherwise -> ERROR.
  - DONE / ERROR: start -> LEN_LO.
- Restart clears cnt, the running XOR, done and error.
- A start pulse in any other state is ignored.
- in_ready is 1 exactly in LEN_LO, LEN_HI, DATA and CSUM.
- Write path:
  - mem_we, mem_addr and mem_wdata are registered; mem_we is a single-cycle pulse for each accepted DATA byte.
  - mem_addr is zero-extended cnt.
  - mem_we is never asserted in any other state.
- Arithmetic: cnt is 16 bits, compared against the 16-bit LEN. The running XOR is 8 bits.
- Memory contents are not cleared by a restart or by an error.
- Reset mid-load: the load aborts immediately. The block returns to IDLE with cpu_hold=1, and a partial image remains in memory.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, cpu_hold=1.
- start seen at edge N: in_ready=1 and busy=1 after edge N.
- Payload byte accepted at edge N: mem_we=1 with that byte's address and data during the cycle following edge N.
- CSUM byte accepted at edge N: after edge N, either done=1 and cpu_hold=0, or error=1. In both cases in_ready=0 and busy=0.
- Oversize LEN: error=1 after the edge that accepts LEN_HI; no memory writes occur.
- Minimum load time: LEN+3 accepted cycles after start.
- in_valid held low stalls the block in its current state indefinitely; no timeout.

## Test plan
- Basic load: reset, start, stream 04 00 13 05 00 00 16 (payload 13 05 00 00, XOR 16).
  - Required: writes 0x13@0, 0x05@1, 0x00@2, 0x00@3.
  - Then done=1, cpu_hold=0, error=0.
- Full memory with stalls: LEN=36 (0x24 0x00), 36 bytes, correct CSUM, with in_valid randomly deasserted.
  - Required: exactly 36 mem_we pulses at addresses 0..35, then done=1.
- Bad checksum: same stream as the basic load, but CSUM=0x17.
  - Required: all four writes occur, then error=1, done=0, cpu_hold=1.
- Oversize and zero length:
  - LEN=37 (0x25 0x00) -> error=1 right after LEN_HI, no mem_we.
  - Then start, LEN=0, CSUM=0x00 -> done=1, no mem_we.
- Reset mid-load: assert reset after 2 payload bytes have been accepted.
  - Required: all outputs return to reset values within the same cycle (asynchronous).
  - Then start and a full good stream -> done=1.
- Ignored start: pulse start while in DATA.
  - Required: no restart, cnt continues, load completes with done=1.
